golay24_enc_pack: RTL and testbench

GOLAY24_ENC_PACK -- requirements
Module: golay24_enc_pack

---
 rtl/golay24_enc_pack_pkg.sv | 26 ++
 rtl/golay24_enc_pack_enc.sv | 21 ++
 rtl/golay24_enc_pack.sv | 98 +++++++++
 tb/tb_golay24_enc_pack.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/golay24_enc_pack_pkg.sv
// Shared extended Golay (24,12) definitions: parity rows, widths and the
// packer FSM encoding. The Golay decoder imports this package as well.
package golay24_enc_pack_pkg;

  localparam int DATA_W = 12;
  localparam int PAR_W  = 12;
  localparam int CW_W   = 24;
  localparam int DOUT_W = 16;

  // Row r is XORed into the parity whenever data bit r is set.
  localparam logic [PAR_W-1:0] B_ROW [DATA_W] = '{
    12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
    12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE
  };

  typedef logic [CW_W-1:0] codeword_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE_A,
    ST_EMIT0,
    ST_EMIT1,
    ST_EMIT2
  } state_t;

endpackage

// File: rtl/golay24_enc_pack_enc.sv
// Combinational systematic Golay (24,12) encoder: codeword = {data, parity}.
module golay24_enc
  import golay24_enc_pack_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output codeword_t         codeword
);

  logic [PAR_W-1:0] parity;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    parity = '0;
    for (int r = 0; r < DATA_W; r++) begin
      if (din[r]) parity = parity ^ B_ROW[r];
    end
    codeword = {din, parity};
  end

endmodule

// File: rtl/golay24_enc_pack.sv
// Encodes 12-bit words to Golay (24,12) and packs codeword pairs (48 bits)
// into three 16-bit words for the PROM writer, with a flush for odd counts.
module golay24_enc_pack
  import golay24_enc_pack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VLD,
  output logic              DIN_RDY,
  input  logic              FLUSH,
  output logic [DOUT_W-1:0] DOUT,
  output logic              DOUT_VLD,
  input  logic              DOUT_RDY,
  output logic              BUSY,
  output logic [CNT_W-1:0]  WORD_CNT
);

  state_t     state_q, state_next;
  codeword_t  cw;
  codeword_t  a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic       din_fire, dout_fire;

  golay24_enc u_enc (
    .din      (DIN),
    .codeword (cw)
  );

  assign din_fire  = DIN_VLD & DIN_RDY;
  assign dout_fire = DOUT_VLD & DOUT_RDY;
  assign WORD_CNT  = cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      ST_IDLE:   if (din_fire)           state_next = ST_HAVE_A;
      ST_HAVE_A: if (din_fire || FLUSH)  state_next = ST_EMIT0;
      ST_EMIT0:  if (dout_fire)          state_next = ST_EMIT1;
      ST_EMIT1:  if (dout_fire)          state_next = ST_EMIT2;
      ST_EMIT2:  if (dout_fire)          state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // Readiness and output data depend on the state alone, never on DOUT_RDY.
  always_comb begin
    DIN_RDY  = 1'b0;
    DOUT_VLD = 1'b0;
    DOUT     = '0;
    BUSY     = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE, ST_HAVE_A: DIN_RDY = 1'b1;
      ST_EMIT0: begin
        DOUT_VLD = 1'b1;
        DOUT     = a_q[23:8];
      end
      ST_EMIT1: begin
        DOUT_VLD = 1'b1;
        DOUT     = {a_q[7:0], b_q[23:16]};
      end
      ST_EMIT2: begin
        DOUT_VLD = 1'b1;
        DOUT     = b_q[15:0];
      end
      default: ;
    endcase
  end

  // Data taken alongside a FLUSH wins; a bare FLUSH pads B with zeros.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (state_q == ST_IDLE && din_fire) a_q <= cw;
      if (state_q == ST_HAVE_A) begin
        if (din_fire)   b_q <= cw;
        else if (FLUSH) b_q <= '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            cnt_q <= '0;
    else if (dout_fire) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_golay24_enc_pack.sv
// Directed bench for golay24_enc_pack: known vectors, flush, backpressure,
// reset mid-emission and a sweep of all 4096 data words.
module tb_golay24_enc_pack;

  logic        CLK = 1'b0;
  logic        RST;
  logic [11:0] DIN;
  logic        DIN_VLD;
  logic        DIN_RDY;
  logic        FLUSH;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        DOUT_RDY;
  logic        BUSY;
  logic [15:0] WORD_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  golay24_enc_pack #(.CNT_W(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .DIN_VLD  (DIN_VLD),
    .DIN_RDY  (DIN_RDY),
    .FLUSH    (FLUSH),
    .DOUT     (DOUT),
    .DOUT_VLD (DOUT_VLD),
    .DOUT_RDY (DOUT_RDY),
    .BUSY     (BUSY),
    .WORD_CNT (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference parity rows, written out independently of the design package.
  logic [11:0] rows [12] = '{
    12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
    12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE
  };

  function automatic logic [23:0] enc_model(input logic [11:0] d);
    logic [11:0] p;
    p = '0;
    for (int r = 0; r < 12; r++) if (d[r]) p = p ^ rows[r];
    return {d, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pair(input logic [11:0] a, input logic [11:0] b);
    DIN_VLD = 1'b1;
    DIN     = a;
    step();
    DIN     = b;
    step();
    DIN_VLD = 1'b0;
  endtask

  // Take one DOUT word with DOUT_RDY high, bounded wait.
  task automatic get_word(input string tag, output logic [15:0] w);
    int budget;
    budget   = 20;
    DOUT_RDY = 1'b1;
    while (!DOUT_VLD && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    w = DOUT;
    step();
  endtask

  task automatic expect_words(input string tag, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] w;
    get_word(tag, w); check({tag, "_w0"}, 32'(w), 32'(w0));
    get_word(tag, w); check({tag, "_w1"}, 32'(w), 32'(w1));
    get_word(tag, w); check({tag, "_w2"}, 32'(w), 32'(w2));
  endtask

  initial begin
    logic [15:0] w0, w1, w2, held;
    logic [23:0] ca, cb, ea, eb;
    logic [47:0] pk;

    RST = 1'b1; DIN = '0; DIN_VLD = 1'b0; FLUSH = 1'b0; DOUT_RDY = 1'b0;
    step(); step();
    check("rst_din_rdy",  32'(DIN_RDY),  32'd1);
    check("rst_busy",     32'(BUSY),     32'd0);
    check("rst_dout_vld", 32'(DOUT_VLD), 32'd0);
    check("rst_dout",     32'(DOUT),     32'd0);
    check("rst_word_cnt", 32'(WORD_CNT), 32'd0);
    @(negedge CLK); RST = 1'b0;
    step();

    // Unit vector pair: 001 -> 001DC5, 000 -> 000000.
    DIN_VLD = 1'b1; DIN = 12'h001;
    step();
    check("have_a_busy",    32'(BUSY),     32'd1);
    check("have_a_din_rdy", 32'(DIN_RDY),  32'd1);
    check("have_a_no_vld",  32'(DOUT_VLD), 32'd0);
    DIN = 12'h000;
    step();
    DIN_VLD = 1'b0;
    check("latency_vld",    32'(DOUT_VLD), 32'd1);
    check("emit_din_rdy",   32'(DIN_RDY),  32'd0);
    expect_words("unit", 16'h001D, 16'hC500, 16'h0000);
    check("unit_cnt",       32'(WORD_CNT), 32'd3);
    check("unit_idle_vld",  32'(DOUT_VLD), 32'd0);
    check("unit_idle_rdy",  32'(DIN_RDY),  32'd1);

    // Flush a half pair: 800 -> 800FFE, zero pad.
    DOUT_RDY = 1'b0;
    DIN_VLD = 1'b1; DIN = 12'h800;
    step();
    DIN_VLD = 1'b0; FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    expect_words("flush", 16'h800F, 16'hFE00, 16'h0000);
    check("flush_idle_rdy",  32'(DIN_RDY),  32'd1);
    check("flush_idle_busy", 32'(BUSY),     32'd0);
    check("flush_cnt",       32'(WORD_CNT), 32'd6);

    // FLUSH in IDLE produces nothing.
    DOUT_RDY = 1'b1; FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    check("idle_flush_vld",  32'(DOUT_VLD), 32'd0);
    check("idle_flush_busy", 32'(BUSY),     32'd0);
    step();
    check("idle_flush_cnt",  32'(WORD_CNT), 32'd6);

    // Backpressure in EMIT1 for 5 cycles.
    DOUT_RDY = 1'b0;
    ea = enc_model(12'h123); eb = enc_model(12'h456);
    pk = {ea, eb};
    send_pair(12'h123, 12'h456);
    check("bp_w0", 32'(DOUT), 32'(pk[47:32]));
    DOUT_RDY = 1'b1;
    step();
    DOUT_RDY = 1'b0;
    held = DOUT;
    check("bp_w1_first", 32'(held), 32'(pk[31:16]));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_dout", 32'(DOUT),     32'(pk[31:16]));
      check("bp_hold_vld",  32'(DOUT_VLD), 32'd1);
      check("bp_hold_rdy",  32'(DIN_RDY),  32'd0);
    end
    check("bp_cnt_mid", 32'(WORD_CNT), 32'd7);
    get_word("bp", w1); check("bp_w1", 32'(w1), 32'(pk[31:16]));
    get_word("bp", w2); check("bp_w2", 32'(w2), 32'(pk[15:0]));
    check("bp_cnt_end", 32'(WORD_CNT), 32'd9);
    check("bp_idle",    32'(DOUT_VLD), 32'd0);

    // Data and FLUSH together in HAVE_A: data wins; FLUSH during EMIT ignored.
    DOUT_RDY = 1'b0;
    ea = enc_model(12'hABC); eb = enc_model(12'h5A5);
    pk = {ea, eb};
    DIN_VLD = 1'b1; DIN = 12'hABC;
    step();
    DIN = 12'h5A5; FLUSH = 1'b1;
    step();
    DIN_VLD = 1'b0;
    expect_words("both", pk[47:32], pk[31:16], pk[15:0]);
    FLUSH = 1'b0;
    check("both_no_pad_vld", 32'(DOUT_VLD), 32'd0);
    check("both_cnt",        32'(WORD_CNT), 32'd12);

    // Reset pulsed in EMIT1.
    DOUT_RDY = 1'b0;
    send_pair(12'hFFF, 12'h0F0);
    DOUT_RDY = 1'b1;
    step();
    DOUT_RDY = 1'b0;
    check("pre_rst_vld", 32'(DOUT_VLD), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_async_vld",  32'(DOUT_VLD), 32'd0);
    check("rst_async_cnt",  32'(WORD_CNT), 32'd0);
    check("rst_async_dout", 32'(DOUT),     32'd0);
    check("rst_async_rdy",  32'(DIN_RDY),  32'd1);
    @(negedge CLK); RST = 1'b0;
    step();
    DOUT_RDY = 1'b1;
    check("post_rst_idle", 32'(DOUT_VLD), 32'd0);
    DOUT_RDY = 1'b0;
    send_pair(12'h001, 12'h000);
    expect_words("post_rst", 16'h001D, 16'hC500, 16'h0000);
    check("post_rst_cnt", 32'(WORD_CNT), 32'd3);

    // Sweep all 4096 data words in pairs.
    for (int d = 0; d < 4096; d += 2) begin
      DOUT_RDY = 1'b0;
      send_pair(12'(d), 12'(d + 1));
      get_word("sweep", w0);
      get_word("sweep", w1);
      get_word("sweep", w2);
      ca = {w0, w1[15:8]};
      cb = {w1[7:0], w2};
      check("sweep_cw_a", 32'(ca), 32'(enc_model(12'(d))));
      check("sweep_cw_b", 32'(cb), 32'(enc_model(12'(d + 1))));
      if (d != 0) check("sweep_wt_a", 32'($countones(ca) >= 8), 32'd1);
      check("sweep_wt_b", 32'($countones(cb) >= 8), 32'd1);
    end
    check("sweep_cnt", 32'(WORD_CNT), 32'(16'(3 + 3 * 2048)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
